vga_timing: RTL and testbench



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_pix_div.sv | 20 ++
 rtl/vga_timing.sv | 87 ++++++++
 tb/tb_vga_timing.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and helpers for timing and renderers
package vga_pkg;

    localparam int VGA_CNT_W     = 10;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_HS_FIRST  = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_HS_LAST   = VGA_HS_FIRST + VGA_H_SYNC - 1;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_VS_FIRST  = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_VS_LAST   = VGA_VS_FIRST + VGA_V_SYNC - 1;

    function automatic logic in_range(input logic [VGA_CNT_W-1:0] v,
                                      input logic [VGA_CNT_W-1:0] lo,
                                      input logic [VGA_CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - divide-by-2 pixel tick; phase toggles every clk, tick on odd phase
module vga_pix_div (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    assign tick = phase;

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA counters/syncs; define VGA_CLKDIV2_EN to advance on every second clk
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       tick_en;
    logic       x_last;
    logic       y_last;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

`ifdef VGA_CLKDIV2_EN
    vga_pix_div u_pix_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_en)
    );
`else
    assign tick_en = 1'b1;
`endif

    // Outputs are registered from the next counter values so syncs line up with pix_x/pix_y.
    always_comb begin
        x_last = (pix_x == H_LAST);
        y_last = (pix_y == V_LAST);
        x_nxt  = pix_x;
        y_nxt  = pix_y;
        if (tick_en) begin
            x_nxt = x_last ? 10'd0 : pix_x + 10'd1;
            if (x_last) begin
                y_nxt = y_last ? 10'd0 : pix_y + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x       <= H_LAST;
            pix_y       <= V_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_x       <= x_nxt;
            pix_y       <= y_nxt;
            hsync       <= ~in_range(x_nxt, HS_FIRST, HS_LAST);
            vsync       <= ~in_range(y_nxt, VS_FIRST, VS_LAST);
            video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            pix_tick    <= tick_en;
            line_start  <= tick_en && x_last;
            frame_start <= tick_en && x_last && y_last;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed checks of vga_timing on a reduced-size and a default-size instance
module tb_vga_timing;

`ifdef VGA_CLKDIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // Reduced geometry: H 20/3/5/4 = 32, V 10/2/2/3 = 17, frame = 544 pixels.
    localparam int S_FRAME = 544;

    logic       clk;
    logic       rst_n;

    logic [9:0] s_x, s_y;
    logic       s_hs, s_vs, s_von, s_tick, s_ls, s_fs;
    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_von, d_tick, d_ls, d_fs;

    int tests  = 0;
    int errors = 0;

    vga_timing #(
        .H_VISIBLE (20), .H_FRONT (3), .H_SYNC (5), .H_BACK (4),
        .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) u_small (
        .clk (clk), .rst_n (rst_n), .pix_x (s_x), .pix_y (s_y),
        .hsync (s_hs), .vsync (s_vs), .video_on (s_von), .pix_tick (s_tick),
        .line_start (s_ls), .frame_start (s_fs)
    );

    vga_timing u_dflt (
        .clk (clk), .rst_n (rst_n), .pix_x (d_x), .pix_y (d_y),
        .hsync (d_hs), .vsync (d_vs), .video_on (d_von), .pix_tick (d_tick),
        .line_start (d_ls), .frame_start (d_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc, fs_n, fs1, fs2;
        int ex, ey, model_err;
        logic etick;
        int von_cnt, vs_cnt, ls_cnt, vs_lines, hs_row0, max_x, max_y;
        int d_fs1, d_low_x, d_high_x, d_low_cnt;
        logic d_prev_hs, found;

        rst_n = 1'b0;
        repeat (3) tick_sample();

        check("rst_s_x", s_x, 31);
        check("rst_s_y", s_y, 16);
        check("rst_s_hs", s_hs, 1);
        check("rst_s_vs", s_vs, 1);
        check("rst_s_von", s_von, 0);
        check("rst_s_ls", s_ls, 0);
        check("rst_s_fs", s_fs, 0);
        check("rst_s_tick", s_tick, 0);
        check("rst_d_x", d_x, 799);
        check("rst_d_y", d_y, 524);
        check("rst_d_misc", {d_hs, d_vs, d_von, d_ls, d_fs, d_tick}, 6'b110000);

        rst_n = 1'b1;
        ex = 31; ey = 16; model_err = 0;
        fs_n = 0; fs1 = -1; fs2 = -1;
        von_cnt = 0; vs_cnt = 0; ls_cnt = 0; vs_lines = 0; hs_row0 = 0;
        max_x = 0; max_y = 0;
        d_fs1 = -1; d_low_x = -1; d_high_x = -1; d_low_cnt = 0; d_prev_hs = 1'b1;

        for (cyc = 1; cyc <= 2 * S_FRAME * DIV + 20; cyc++) begin
            tick_sample();
            etick = (DIV == 1) || (cyc % 2 == 0);
            if (etick) begin
                if (ex == 31) begin
                    ex = 0;
                    ey = (ey == 16) ? 0 : ey + 1;
                end else begin
                    ex = ex + 1;
                end
            end
            if (s_x != 10'(ex) || s_y != 10'(ey) || s_tick != etick
                || s_hs != !(ex >= 23 && ex <= 27)
                || s_vs != !(ey >= 12 && ey <= 13)
                || s_von != (ex < 20 && ey < 10)
                || s_ls != (etick && ex == 0)
                || s_fs != (etick && ex == 0 && ey == 0))
                model_err++;

            if (s_fs) begin
                fs_n++;
                if (fs_n == 1) fs1 = cyc;
                if (fs_n == 2) fs2 = cyc;
            end
            if (fs_n == 1) begin
                if (s_von) von_cnt++;
                if (!s_vs) vs_cnt++;
                if (s_ls) ls_cnt++;
                if (s_ls && !s_vs) vs_lines++;
                if (!s_hs && s_y == 10'd0) hs_row0++;
            end
            if (int'(s_x) > max_x) max_x = int'(s_x);
            if (int'(s_y) > max_y) max_y = int'(s_y);

            if (d_fs && d_fs1 < 0 && d_x == 10'd0 && d_y == 10'd0) d_fs1 = cyc;
            if (d_y == 10'd0 && d_fs1 >= 0) begin
                if (!d_hs) d_low_cnt++;
                if (d_prev_hs && !d_hs && d_low_x < 0) d_low_x = int'(d_x);
                if (!d_prev_hs && d_hs && d_high_x < 0) d_high_x = int'(d_x);
            end
            d_prev_hs = d_hs;
        end

        check("model_err", model_err, 0);
        check("fs_first_cycle", fs1, DIV);
        check("fs_period", fs2 - fs1, S_FRAME * DIV);
        check("video_on_per_frame", von_cnt, 200 * DIV);
        check("vsync_low_cycles", vs_cnt, 64 * DIV);
        check("vsync_low_lines", vs_lines, 2);
        check("lines_per_frame", ls_cnt, 17);
        check("hsync_low_row0", hs_row0, 5 * DIV);
        check("max_x", max_x, 31);
        check("max_y", max_y, 16);
        check("d_fs_first_cycle", d_fs1, DIV);
        check("d_hsync_first_low_x", d_low_x, 656);
        check("d_hsync_high_again_x", d_high_x, 752);
        check("d_hsync_low_cycles", d_low_cnt, 96 * DIV);

        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME * DIV && !found; i++) begin
            tick_sample();
            if (s_x == 10'd25 && s_y == 10'd7) found = 1'b1;
        end
        check("midframe_reached", found, 1);

        rst_n = 1'b0;
        #1;
        check("mid_rst_x", s_x, 31);
        check("mid_rst_y", s_y, 16);
        check("mid_rst_hs", s_hs, 1);
        check("mid_rst_vs", s_vs, 1);
        check("mid_rst_pulses", {s_von, s_ls, s_fs, s_tick}, 0);
        fs_n = 0;
        repeat (3) begin
            tick_sample();
            if (s_fs || s_ls) fs_n++;
        end
        check("mid_rst_no_pulse", fs_n, 0);
        check("mid_rst_hold_x", s_x, 31);

        rst_n = 1'b1;
        fs_n = 0;
        for (int i = 1; i <= DIV; i++) begin
            tick_sample();
            if (s_fs) fs_n++;
        end
        check("restart_fs_count", fs_n, 1);
        check("restart_fs", s_fs, 1);
        check("restart_ls", s_ls, 1);
        check("restart_xy", {s_x, s_y}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
